peak_frame_controller: RTL and testbench

- Sequences frame-by-frame peak-bin search over the FFT magnitude stream; one result per DEPTH-bin frame.
- Aligns to frame starts and checks bin ordering; per frame, latches the search window and threshold, clears the running max and tracks the strongest bin.
- Publishes {peak_k, peak_mag, peak_found} through a one-deep valid/ready output buffer to the pitch-estimation stage.
- Flags dropped results and sequence errors.

---
 rtl/peak_frame_controller.sv | 132 +++++++++++++
 tb/tb_peak_frame_controller.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/peak_frame_controller.sv
// rtl/peak_frame_controller.sv - per-frame peak-bin search over an FFT magnitude stream
// One result per DEPTH-bin frame, held in a one-deep valid/ready buffer.
module peak_frame_controller #(
  parameter int DEPTH     = 4096,
  parameter int MAG_WIDTH = 96,
  parameter int K_WIDTH   = 12
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 clear_flags,
  input  logic [K_WIDTH-1:0]   cfg_k_lo,
  input  logic [K_WIDTH-1:0]   cfg_k_hi,
  input  logic [MAG_WIDTH-1:0] cfg_threshold,
  input  logic                 data_valid,
  input  logic [MAG_WIDTH-1:0] data_in,
  input  logic [K_WIDTH-1:0]   k_in,
  output logic                 peak_valid,
  input  logic                 peak_ready,
  output logic [K_WIDTH-1:0]   peak_k,
  output logic [MAG_WIDTH-1:0] peak_mag,
  output logic                 peak_found,
  output logic                 busy,
  output logic                 overrun,
  output logic                 seq_error
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [K_WIDTH-1:0] LAST_K = K_WIDTH'(DEPTH - 1);

  state_t               state;
  logic [K_WIDTH-1:0]   exp_k;
  logic [K_WIDTH-1:0]   win_lo_q, win_hi_q;
  logic [MAG_WIDTH-1:0] thr_q;
  logic [MAG_WIDTH-1:0] run_max;
  logic [K_WIDTH-1:0]   run_k;
  logic                 run_found;

  logic                 start, in_seq, bad_seq, frame_end, accept, upd;
  logic [K_WIDTH-1:0]   win_lo, win_hi;
  logic [MAG_WIDTH-1:0] win_thr;
  logic [MAG_WIDTH-1:0] nxt_max;
  logic [K_WIDTH-1:0]   nxt_k;
  logic                 nxt_found;

  assign start     = (state == IDLE) && enable && data_valid && (k_in == '0);
  assign in_seq    = (state == SCAN) && enable && data_valid && (k_in == exp_k);
  assign bad_seq   = (state == SCAN) && enable && data_valid && (k_in != exp_k);
  assign frame_end = in_seq && (k_in == LAST_K);
  assign accept    = peak_valid && peak_ready;

  // The first bin of a frame is judged against the live config, which is latched on that same edge.
  always_comb begin
    win_lo  = start ? cfg_k_lo      : win_lo_q;
    win_hi  = start ? cfg_k_hi      : win_hi_q;
    win_thr = start ? cfg_threshold : thr_q;
    upd = (start || in_seq) && (k_in >= win_lo) && (k_in <= win_hi) && (data_in >= win_thr)
          && (start || !run_found || (data_in > run_max));
    nxt_max   = start ? '0 : run_max;
    nxt_k     = start ? '0 : run_k;
    nxt_found = start ? 1'b0 : run_found;
    if (upd) begin
      nxt_max   = data_in;
      nxt_k     = k_in;
      nxt_found = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      exp_k      <= '0;
      win_lo_q   <= '0;
      win_hi_q   <= '0;
      thr_q      <= '0;
      run_max    <= '0;
      run_k      <= '0;
      run_found  <= 1'b0;
      peak_valid <= 1'b0;
      peak_k     <= '0;
      peak_mag   <= '0;
      peak_found <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      seq_error  <= 1'b0;
    end else begin
      run_max   <= nxt_max;
      run_k     <= nxt_k;
      run_found <= nxt_found;

      case (state)
        IDLE: begin
          if (start) begin
            state    <= SCAN;
            busy     <= 1'b1;
            exp_k    <= K_WIDTH'(1);
            win_lo_q <= cfg_k_lo;
            win_hi_q <= cfg_k_hi;
            thr_q    <= cfg_threshold;
          end
        end
        SCAN: begin
          if (!enable || bad_seq || frame_end) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (in_seq) begin
            exp_k <= exp_k + K_WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // run_k/run_max stay zero unless a bin qualified, so a no-peak result publishes zeros.
      if (frame_end && (!peak_valid || accept)) begin
        peak_valid <= 1'b1;
        peak_k     <= nxt_k;
        peak_mag   <= nxt_max;
        peak_found <= nxt_found;
      end else if (accept) begin
        peak_valid <= 1'b0;
      end

      overrun   <= (overrun && !clear_flags) || (frame_end && peak_valid && !peak_ready);
      seq_error <= (seq_error && !clear_flags) || bad_seq;
    end
  end

endmodule

// File: tb/tb_peak_frame_controller.sv
// tb/tb_peak_frame_controller.sv - scoreboard bench for peak_frame_controller
// Frame-level reference model feeds an expected-result queue drained by a monitor.
module tb_peak_frame_controller;

  localparam int DEPTH = 8;
  localparam int KW    = 3;
  localparam int MW    = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          clear_flags = 1'b0;
  logic [KW-1:0] cfg_k_lo = '0;
  logic [KW-1:0] cfg_k_hi = '0;
  logic [MW-1:0] cfg_threshold = '0;
  logic          data_valid = 1'b0;
  logic [MW-1:0] data_in = '0;
  logic [KW-1:0] k_in = '0;
  logic          peak_ready = 1'b0;
  logic          peak_valid;
  logic [KW-1:0] peak_k;
  logic [MW-1:0] peak_mag;
  logic          peak_found;
  logic          busy;
  logic          overrun;
  logic          seq_error;

  peak_frame_controller #(.DEPTH(DEPTH), .MAG_WIDTH(MW), .K_WIDTH(KW)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .clear_flags(clear_flags),
    .cfg_k_lo(cfg_k_lo), .cfg_k_hi(cfg_k_hi), .cfg_threshold(cfg_threshold),
    .data_valid(data_valid), .data_in(data_in), .k_in(k_in),
    .peak_valid(peak_valid), .peak_ready(peak_ready), .peak_k(peak_k),
    .peak_mag(peak_mag), .peak_found(peak_found), .busy(busy),
    .overrun(overrun), .seq_error(seq_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    int k;
    int mag;
    bit found;
  } res_t;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  bit   m_in_frame = 1'b0;
  int   m_nk = 0;
  int   m_lo = 0, m_hi = 0, m_thr = 0;
  int   m_mags[DEPTH];
  bit   m_full = 1'b0, m_seq = 1'b0, m_ovr = 1'b0;
  int   fm[DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Strongest eligible magnitude first, then the lowest bin holding it.
  function automatic res_t best_of();
    res_t r;
    int best = -1;
    r.k = 0; r.mag = 0; r.found = 1'b0;
    for (int k = 0; k < DEPTH; k++)
      if (k >= m_lo && k <= m_hi && m_mags[k] >= m_thr && m_mags[k] > best) best = m_mags[k];
    if (best >= 0) begin
      for (int k = DEPTH - 1; k >= 0; k--)
        if (k >= m_lo && k <= m_hi && m_mags[k] == best) r.k = k;
      r.mag = best;
      r.found = 1'b1;
    end
    return r;
  endfunction

  // Applies the effect of the clock edge that just sampled the held inputs.
  task automatic model_update();
    bit accept = m_full && peak_ready;
    bit fend = 1'b0;
    res_t r;
    if (clear_flags) begin
      m_seq = 1'b0;
      m_ovr = 1'b0;
    end
    if (!m_in_frame) begin
      if (enable && data_valid && k_in == 0) begin
        m_lo = int'(cfg_k_lo); m_hi = int'(cfg_k_hi); m_thr = int'(cfg_threshold);
        m_mags[0] = int'(data_in);
        m_nk = 1;
        m_in_frame = 1'b1;
      end
    end else if (!enable) begin
      m_in_frame = 1'b0;
    end else if (data_valid) begin
      if (int'(k_in) != m_nk) begin
        m_seq = 1'b1;
        m_in_frame = 1'b0;
      end else begin
        m_mags[m_nk] = int'(data_in);
        if (m_nk == DEPTH - 1) begin
          fend = 1'b1;
          m_in_frame = 1'b0;
        end else m_nk++;
      end
    end
    if (fend) begin
      r = best_of();
      if (!m_full || accept) begin
        exp_q.push_back(r);
        m_full = 1'b1;
      end else m_ovr = 1'b1;
    end else if (accept) m_full = 1'b0;
  endtask

  task automatic cycle(input bit en, input bit dv, input int k, input int mag, input bit rdy, input bit clr);
    enable = en; data_valid = dv; k_in = KW'(k); data_in = MW'(mag);
    peak_ready = rdy; clear_flags = clr;
    @(posedge clock);
    #1;
    model_update();
  endtask

  task automatic run_frame(input bit rdy);
    for (int k = 0; k < DEPTH; k++) cycle(1'b1, 1'b1, k, fm[k], rdy, 1'b0);
  endtask

  task automatic set_cfg(input int lo, input int hi, input int thr);
    cfg_k_lo = KW'(lo); cfg_k_hi = KW'(hi); cfg_threshold = MW'(thr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
  endtask

  always @(negedge clock) begin
    if (mon_en && reset_n) begin
      chk("busy", busy, m_in_frame);
      chk("seq_error", seq_error, m_seq);
      chk("overrun", overrun, m_ovr);
      chk("peak_valid", peak_valid, m_full);
      if (peak_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL result: unexpected result k=%0d mag=%0d, none expected", peak_k, peak_mag);
        end else begin
          chk("peak_k", peak_k, exp_q[0].k);
          chk("peak_mag", peak_mag, exp_q[0].mag);
          chk("peak_found", peak_found, exp_q[0].found);
          if (peak_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int kptr;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_peak_valid", peak_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {overrun, seq_error}, 0);
    chk("rst_peak_data", {peak_k, peak_mag, peak_found}, 0);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    mon_en = 1'b1;

    // basic frame, tie keeps k=3
    fm = '{5, 9, 3, 20, 20, 1, 0, 7};
    set_cfg(0, 7, 0);
    run_frame(1'b1);
    chk("t1_valid", peak_valid, 1);
    chk("t1_k", peak_k, 3);
    chk("t1_mag", peak_mag, 20);
    chk("t1_found", peak_found, 1);
    idle(2);

    set_cfg(4, 6, 2);
    run_frame(1'b1);
    chk("t2_k", peak_k, 4);
    chk("t2_mag", peak_mag, 20);
    set_cfg(4, 6, 25);
    run_frame(1'b1);
    chk("t2b_valid", peak_valid, 1);
    chk("t2b_found", peak_found, 0);
    chk("t2b_kmag", {peak_k, peak_mag}, 0);
    idle(2);

    // mid-frame join
    set_cfg(0, 7, 0);
    for (int k = 5; k < DEPTH; k++) cycle(1'b1, 1'b1, k, 50, 1'b1, 1'b0);
    fm = '{1, 2, 3, 4, 5, 6, 7, 8};
    run_frame(1'b1);
    chk("t3_k", peak_k, 7);
    idle(2);
    chk("t3_seq", seq_error, 0);

    // sequence error
    cycle(1'b1, 1'b1, 0, 3, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1, 3, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 2, 3, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 4, 3, 1'b1, 1'b0);
    chk("t4_seq", seq_error, 1);
    chk("t4_busy", busy, 0);
    fm = '{0, 0, 9, 0, 0, 0, 0, 0};
    run_frame(1'b1);
    chk("t4_k", peak_k, 2);
    cycle(1'b1, 1'b0, 0, 0, 1'b1, 1'b1);
    chk("t4_clr", seq_error, 0);
    idle(2);

    // overrun: second back-to-back frame is dropped
    fm = '{5, 9, 3, 20, 20, 1, 0, 7};
    run_frame(1'b0);
    fm = '{1, 1, 1, 1, 1, 1, 40, 1};
    run_frame(1'b0);
    chk("t5_ovr", overrun, 1);
    chk("t5_k_held", peak_k, 3);
    cycle(1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
    chk("t5_drain", peak_valid, 0);
    cycle(1'b1, 1'b0, 0, 0, 1'b1, 1'b1);
    idle(1);

    // async reset mid-frame with a buffered result
    run_frame(1'b0);
    cycle(1'b1, 1'b1, 0, 3, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1, 3, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("ar_valid", peak_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_data", {peak_k, peak_mag, peak_found}, 0);
    m_in_frame = 1'b0; m_full = 1'b0; m_seq = 1'b0; m_ovr = 1'b0;
    exp_q.delete();
    data_valid = 1'b0;
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock);
    #1;
    mon_en = 1'b1;
    fm = '{2, 2, 2, 2, 2, 11, 2, 2};
    set_cfg(0, 7, 0);
    run_frame(1'b1);
    chk("ar_frame_k", peak_k, 5);
    idle(2);

    // randomized stream
    kptr = 0;
    for (int i = 0; i < 600; i++) begin
      int k;
      bit dv;
      if ($urandom_range(0, 15) == 0) set_cfg($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31));
      dv = ($urandom_range(0, 3) != 0);
      k = ($urandom_range(0, 24) == 0) ? $urandom_range(0, 7) : kptr;
      if (dv) kptr = (k + 1) % DEPTH;
      cycle($urandom_range(0, 40) != 0, dv, k, $urandom_range(0, 31),
            $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
